// File: rtl/bit_frame_collector.sv
// ---------------------------------------------------------------------------
// bit_frame_collector
//
// Serial-to-parallel front end. Single-bit samples are assembled into a
// WIDTH-bit word that feeds the ones-count encoder input `x`. A frame begins
// with a `start` pulse. The finished word is held on `x_out` under a
// valid/ready handshake until the consumer accepts it. Bits, or `start`
// pulses without `frame_ready`, that arrive while a frame is held set the
// sticky `overrun` flag.
//
// Parameters:
//   WIDTH      bits per frame (>= 2; the downstream encoder consumes 7)
//   LSB_FIRST  1: first bit lands in x_out[0]; 0: first bit lands in x_out[WIDTH-1]
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   frame-sync pulse, begins a new frame
//   bit_in       in   serial data bit
//   bit_valid    in   bit_in is valid this cycle
//   frame_ready  in   consumer accepts the held frame
//   clr_err      in   synchronous clear of overrun
//   x_out        out  assembled frame (encoder input x)
//   frame_valid  out  x_out holds a complete frame
//   busy         out  high while collecting bits
//   overrun      out  sticky error flag
//   ones_count   out  running count of 1-bits in the current frame
//                     (only present when BIT_FRAME_ONES_COUNT_EN is defined)
//
// Optional feature macro: BIT_FRAME_ONES_COUNT_EN
// ---------------------------------------------------------------------------
module bit_frame_collector #(
   parameter int WIDTH     = 7,
   parameter int LSB_FIRST = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         bit_in,
   input  logic                         bit_valid,
   input  logic                         frame_ready,
   input  logic                         clr_err,
   output logic [WIDTH-1:0]             x_out,
   output logic                         frame_valid,
   output logic                         busy,
`ifdef BIT_FRAME_ONES_COUNT_EN
   output logic [$clog2(WIDTH+1)-1:0]   ones_count,
`endif
   output logic                         overrun
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      HOLD
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shiftReg_q;
   logic [WIDTH-1:0] shiftReg_d;
   logic [CW-1:0]    bitCount_q;
   logic [CW-1:0]    bitPos;
   logic [WIDTH-1:0] xOut_q;
   logic             frameValid_q;
   logic             busy_q;
   logic             overrun_q;
   logic             frameStart;
   logic             overrunSet;

   // Work out where the incoming bit belongs and what the shift register
   // looks like with it inserted. The completing bit must reach x_out on the
   // same edge, so this view is shared by the shift register and the output
   // load.
   always_comb begin
      bitPos = (LSB_FIRST != 0) ? bitCount_q : (CW'(WIDTH - 1) - bitCount_q);
      shiftReg_d = shiftReg_q;
      shiftReg_d[bitPos] = bit_in;
   end

   // A new frame can open from IDLE, restart from COLLECT, or follow
   // immediately in HOLD when the held frame is accepted in the same cycle.
   // In HOLD, any valid bit is an overrun, and so is a start the consumer
   // did not accept.
   always_comb begin
      frameStart = start && ((state_q != HOLD) || frame_ready);
      overrunSet = (state_q == HOLD) && (bit_valid || (start && !frame_ready));
   end

   // Main frame FSM. busy and frame_valid are registered together with the
   // state, so they always match it exactly. x_out is loaded only when a
   // frame completes. It keeps that value after acceptance until the next
   // frame replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shiftReg_q   <= '0;
         bitCount_q   <= '0;
         xOut_q       <= '0;
         frameValid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= COLLECT;
                  busy_q     <= 1'b1;
                  shiftReg_q <= '0;
                  bitCount_q <= '0;
               end
            end
            COLLECT: begin
               if (start) begin
                  shiftReg_q <= '0;
                  bitCount_q <= '0;
               end else if (bit_valid) begin
                  shiftReg_q <= shiftReg_d;
                  if (bitCount_q == CW'(WIDTH - 1)) begin
                     xOut_q       <= shiftReg_d;
                     frameValid_q <= 1'b1;
                     busy_q       <= 1'b0;
                     state_q      <= HOLD;
                  end else begin
                     bitCount_q <= bitCount_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (frame_ready) begin
                  frameValid_q <= 1'b0;
                  if (start) begin
                     state_q    <= COLLECT;
                     busy_q     <= 1'b1;
                     shiftReg_q <= '0;
                     bitCount_q <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q      <= IDLE;
               frameValid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun flag. A new overrun event beats a clear that arrives in
   // the same cycle, so no error is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (overrunSet) begin
         overrun_q <= 1'b1;
      end else if (clr_err) begin
         overrun_q <= 1'b0;
      end
   end

`ifdef BIT_FRAME_ONES_COUNT_EN
   logic [$clog2(WIDTH+1)-1:0] onesCount_q;

   // Running count of accepted 1-bits. Only bits stored in COLLECT are
   // counted, so in HOLD the count equals the popcount of x_out. That makes
   // it a cross-check against the encoder's y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         onesCount_q <= '0;
      end else if (frameStart) begin
         onesCount_q <= '0;
      end else if ((state_q == COLLECT) && bit_valid) begin
         onesCount_q <= onesCount_q + {{($clog2(WIDTH+1)-1){1'b0}}, bit_in};
      end
   end

   assign ones_count = onesCount_q;
`endif

   assign x_out       = xOut_q;
   assign frame_valid = frameValid_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: doc/bit_frame_collector.md
Name: bit_frame_collector

Overview:
- Serial-to-parallel front end that assembles single-bit samples into a 7-bit word `x` for the ones-count encoder stage downstream.
- Frame boundaries come from a `start` pulse.
- A completed frame is held on `x_out` with a valid/ready handshake until the consumer accepts it.
- Bits arriving while a frame is held, and `start` pulses arriving while a frame is held, are flagged as overrun.

Parameters:
- WIDTH, 7: bits per frame; must be ≥ 2; the downstream encoder consumes 7.
- LSB_FIRST, 1: 1 = first received bit lands in `x_out[0]`; 0 = first bit lands in `x_out[WIDTH-1]`.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame-sync pulse; begins a new frame.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  `bit_in` is valid this cycle.
- frame_ready  in  1  consumer accepts the held frame.
- clr_err  in  1  synchronous clear of `overrun`.
- x_out  out  WIDTH  assembled frame; feeds encoder input `x`.
- frame_valid  out  1  `x_out` holds a complete frame.
- busy  out  1  high in COLLECT.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (async, `rst_n` = 0):
  - state = IDLE, shift register = 0, bit counter = 0.
  - `x_out` = 0, `frame_valid` = 0, `busy` = 0, `overrun` = 0.
  - Reset mid-frame discards the partial frame; no frame is emitted.
- States: IDLE, COLLECT, HOLD. `busy` = (state == COLLECT). `frame_valid` = (state == HOLD), registered.
- IDLE:
  - `bit_valid` is ignored.
  - `start` = 1 -> COLLECT, with shift register cleared and counter = 0.
  - The `start` cycle carries no data bit.
- COLLECT:
  - Each cycle with `bit_valid` = 1: store `bit_in` at position counter (LSB_FIRST = 1) or WIDTH-1-counter (LSB_FIRST = 0); counter++.
  - On the `bit_valid` cycle with counter == WIDTH-1: at the next edge, `x_out` is loaded with all WIDTH bits (including this bit), `frame_valid` = 1, state = HOLD.
  - Latency: `frame_valid` rises 1 cycle after the last bit is sampled.
  - `bit_valid` = 0 cycles are stalls; there is no timeout.
  - `start` = 1 in COLLECT restarts the frame: counter = 0, register cleared, partial data discarded, no error. If `bit_valid` = 1 in the same cycle, that bit is dropped and `start` wins.
- HOLD:
  - `x_out` is stable.
  - `frame_ready` = 1 -> frame accepted; next state IDLE, `frame_valid` = 0.
  - `frame_ready` and `start` in the same cycle -> next state COLLECT directly (back-to-back frames, no idle cycle).
  - `start` without `frame_ready` -> ignored and `overrun` set.
  - `bit_valid` = 1 in HOLD (including the accept cycle) -> bit dropped and `overrun` set.
- `x_out` retains its last frame after acceptance until the next frame loads; it changes only on frame completion or reset.
- `overrun`:
  - Set has priority over `clr_err` in the same cycle.
  - `clr_err` clears it at the next edge otherwise.
- Counter width is `$clog2(WIDTH)`. The counter never exceeds WIDTH-1 because the transition to HOLD happens on the final bit, so no wrap-around occurs.
- `frame_ready` outside HOLD has no effect.

Optional Feature:
- Macro: BIT_FRAME_ONES_COUNT_EN.
- Defined:
  - Adds output `ones_count  out  $clog2(WIDTH+1)`.
  - It is a running count of 1-bits accepted in the current frame.
  - It is cleared on `start`/reset, registered, and valid alongside `frame_valid` in HOLD.
  - It equals the downstream encoder's `y` for the same frame; used as a cross-check.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, `start`, then bits 1,0,1,1,0,0,1 with LSB_FIRST = 1 -> `x_out` = 7'b1001101, `frame_valid` = 1 one cycle after the 7th bit; `ones_count` = 4 if enabled.
- Same stream with LSB_FIRST = 0 -> `x_out` = 7'b1011001.
- Hold `frame_ready` = 0 for 5 cycles, driving `bit_valid` = 1 on cycle 2 -> `x_out` unchanged, `overrun` = 1; `clr_err` then clears it; `frame_ready` = 1 -> `frame_valid` = 0 next cycle.
- `start`, 3 bits of 1, `start` again, then 7 bits of 0 -> `x_out` = 7'b0000000, `overrun` = 0.
- `frame_ready` and `start` in the same HOLD cycle, then 7 bits of 1 -> second frame 7'b1111111 with no IDLE cycle between; `busy` is high the cycle after accept.
- Assert `rst_n` = 0 asynchronously after 4 bits -> all outputs 0 immediately; after release, `bit_valid` without `start` produces no frame.
